// File: rtl/edge_grad_pkg.sv
// rtl/edge_grad_pkg.sv - shared image-processing constants for the edge gradient pipeline
package edge_grad_pkg;

    // Pixel and gradient magnitude widths
    localparam int PIX_W      = 8;
    localparam int MAG_W      = 10;

    // Output saturation value and default binarization threshold
    localparam int SAT_VAL    = 255;
    localparam int DEF_THRESH = 40;

endpackage

// File: rtl/edge_grad_abs_diff8.sv
// rtl/edge_grad_abs_diff8.sv - combinational 8-bit absolute difference |a-b|
module abs_diff8
    import edge_grad_pkg::*;
(
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] y
);

    // Subtract the smaller operand from the larger so the result never wraps
    always_comb begin
        y = '0;
        if (a >= b) begin
            y = a - b;
        end else begin
            y = b - a;
        end
    end

endmodule

// File: rtl/edge_grad.sv
// rtl/edge_grad.sv - 3-stage gradient magnitude pipeline; EDGE_GRAD_BINARY_EN selects thresholded output
module edge_grad
    import edge_grad_pkg::*;
#(
    parameter int COL    = 30,
    parameter int ROW    = 30,
    parameter int THRESH = DEF_THRESH
) (
    input  logic             vga_clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] px1,
    input  logic [PIX_W-1:0] px2,
    input  logic [PIX_W-1:0] px3,
    input  logic [PIX_W-1:0] px4,
    input  logic [PIX_W-1:0] px5,
    input  logic             din_vld,
    output logic [PIX_W-1:0] dout,
    output logic             dout_vld,
    output logic             frame_end
);

    localparam int CW = $clog2(COL);
    localparam int RW = $clog2(ROW);
    localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

    // Position of the pixel currently presented on the inputs
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Stage 1: absolute differences plus position flags
    logic [PIX_W-1:0] diff_a, diff_b, diff_c, diff_d;
    logic [PIX_W-1:0] a_q, b_q, c_q, d_q;
    logic             vld1_q, vld1_d;
    logic             bord1_q, bord1_d;
    logic             last1_q, last1_d;

    // Stage 2: horizontal and vertical gradient sums
    logic [PIX_W:0]   gx_q, gx_d;
    logic [PIX_W:0]   gy_q, gy_d;
    logic             vld2_q, bord2_q, last2_q;

    // Stage 3: output registers
    logic [MAG_W-1:0] mag;
    logic [PIX_W-1:0] dout_q, dout_d;
    logic             dout_vld_q, frame_end_q, frame_end_d;

    abs_diff8 u_abs_a (.a(px3), .b(px1), .y(diff_a));
    abs_diff8 u_abs_b (.a(px5), .b(px4), .y(diff_b));
    abs_diff8 u_abs_c (.a(px5), .b(px3), .y(diff_c));
    abs_diff8 u_abs_d (.a(px4), .b(px2), .y(diff_d));

    // Raster position tracking: column wraps into the row, row wraps at frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (din_vld) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Flags for the incoming pixel: borders lack a full window, last marks frame end
    always_comb begin
        vld1_d  = din_vld;
        bord1_d = (col_q < CW'(2)) || (row_q == '0);
        last1_d = din_vld && (col_q == COL_LAST) && (row_q == ROW_LAST);
    end

    // Gradient sums are widened by one bit so nothing is lost
    always_comb begin
        gx_d = {1'b0, a_q} + {1'b0, b_q};
        gy_d = {1'b0, c_q} + {1'b0, d_q};
    end

    // Final magnitude, border suppression and output mapping
    always_comb begin
        mag         = {1'b0, gx_q} + {1'b0, gy_q};
        frame_end_d = vld2_q && last2_q;
        dout_d      = '0;
        if (!bord2_q) begin
`ifdef EDGE_GRAD_BINARY_EN
            if (mag > MAG_W'(THRESH)) begin
                dout_d = PIX_W'(SAT_VAL);
            end
`else
            if (mag > MAG_W'(SAT_VAL)) begin
                dout_d = PIX_W'(SAT_VAL);
            end else begin
                dout_d = mag[PIX_W-1:0];
            end
`endif
        end
    end

`ifndef EDGE_GRAD_BINARY_EN
    // Threshold only matters for the binary output; keep it referenced without a comparator
    logic [7:0] unused_thresh;
    assign unused_thresh = 8'(THRESH);
`endif

    // All pipeline state; valid and flags shift every cycle so input gaps pass through
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            vld1_q      <= 1'b0;
            bord1_q     <= 1'b0;
            last1_q     <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            vld2_q      <= 1'b0;
            bord2_q     <= 1'b0;
            last2_q     <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            a_q         <= diff_a;
            b_q         <= diff_b;
            c_q         <= diff_c;
            d_q         <= diff_d;
            vld1_q      <= vld1_d;
            bord1_q     <= bord1_d;
            last1_q     <= last1_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            vld2_q      <= vld1_q;
            bord2_q     <= bord1_q;
            last2_q     <= last1_q;
            dout_q      <= dout_d;
            dout_vld_q  <= vld2_q;
            frame_end_q <= frame_end_d;
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign frame_end = frame_end_q;

endmodule
